// File: rtl/irrigacao_zonas_if.sv
// Field-side bundle of the multi-zone irrigation controller: tank sensors,
// per-zone soil/climate inputs, error clear, and valve/status outputs.
interface irrigacao_zonas_if #(
    parameter int unsigned N_ZONAS = 4
);
    localparam int unsigned ZW = $clog2(N_ZONAS);

    logic               alta;
    logic               media;
    logic               baixa;
    logic [N_ZONAS-1:0] solo;
    logic [N_ZONAS-1:0] umidade;
    logic [N_ZONAS-1:0] temperatura;
    logic               clr_erro;

    logic               erro;
    logic               alarme;
    logic               ve;
    logic               caixa;
    logic [N_ZONAS-1:0] gotejamento;
    logic [N_ZONAS-1:0] aspersao;
    logic [ZW-1:0]      zona_ativa;
    logic               ocupado;

    modport master (
        output alta, media, baixa, solo, umidade, temperatura, clr_erro,
        input  erro, alarme, ve, caixa, gotejamento, aspersao, zona_ativa, ocupado
    );

    modport slave (
        input  alta, media, baixa, solo, umidade, temperatura, clr_erro,
        output erro, alarme, ve, caixa, gotejamento, aspersao, zona_ativa, ocupado
    );
endinterface

// File: rtl/irrigacao_zonas.sv
// Tank level filtering, sensor-consistency error latch, fill valve hysteresis and a
// round-robin scheduler serving one irrigation zone at a time with min/max on-times.
module irrigacao_zonas #(
    parameter int unsigned N_ZONAS = 4,
    parameter int unsigned DEB     = 3,
    parameter int unsigned T_MIN   = 8,
    parameter int unsigned T_MAX   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    irrigacao_zonas_if.slave  bus
);
    localparam int unsigned ZW  = $clog2(N_ZONAS);
    localparam int unsigned CW  = $clog2(T_MAX);
    localparam int unsigned DCW = $clog2(DEB + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IRRIGA = 2'd1;
    localparam logic [1:0] PAUSA  = 2'd2;

    // Tank sensors, bit order {alta, media, baixa}
    logic [2:0]          raw;
    logic [2:0]          prev;
    logic [2:0]          filt;
    logic [2:0]          filt_n;
    logic [2:0][DCW-1:0] dcnt;
    logic [2:0][DCW-1:0] dcnt_n;
    logic [2:0][DCW-1:0] drun;

    logic a_f, m_f, b_f, inv;
    logic erro, ve;
    logic caixa_c, alarme_c;

    logic [1:0]         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [ZW-1:0]      ptr, ptr_n;
    logic [ZW-1:0]      zona, zona_n;
    logic [N_ZONAS-1:0] got, got_n;
    logic [N_ZONAS-1:0] asp, asp_n;
    logic               ocupado, ocupado_n;

    logic               found;
    logic [ZW-1:0]      pick;
    logic [ZW-1:0]      idx;
    logic [N_ZONAS-1:0] oh;
    logic               fim;

    assign raw = {bus.alta, bus.media, bus.baixa};

    // Debounce: run length counts consecutive edges a differing raw value has been held
    always_comb begin
        filt_n = filt;
        dcnt_n = '0;
        drun   = '0;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != filt[i]) begin
                drun[i] = (raw[i] == prev[i]) ? dcnt[i] + DCW'(1) : DCW'(1);
                if (32'(drun[i]) >= DEB) begin
                    filt_n[i] = raw[i];
                end else begin
                    dcnt_n[i] = drun[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            filt <= '0;
            dcnt <= '0;
        end else begin
            prev <= raw;
            filt <= filt_n;
            dcnt <= dcnt_n;
        end
    end

    assign a_f      = filt[2];
    assign m_f      = filt[1];
    assign b_f      = filt[0];
    assign inv      = ~((~a_f | m_f) & (~m_f | b_f));
    assign caixa_c  = b_f & ~inv & ~erro;
    assign alarme_c = ~b_f & ~inv & ~erro;

    // Error latch (set wins over clear) and fill valve hysteresis between media and alta
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erro <= 1'b0;
            ve   <= 1'b0;
        end else begin
            if (inv) begin
                erro <= 1'b1;
            end else if (bus.clr_erro) begin
                erro <= 1'b0;
            end
            if (a_f | inv | erro) begin
                ve <= 1'b0;
            end else if (!m_f) begin
                ve <= 1'b1;
            end
        end
    end

    // Round-robin arbiter: first requesting zone at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = '0;
        for (int k = int'(N_ZONAS) - 1; k >= 0; k--) begin
            idx = ZW'((32'(ptr) + 32'(k)) % N_ZONAS);
            if (bus.solo[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign oh  = N_ZONAS'(1) << pick;
    assign fim = ~caixa_c
               | ((cnt >= CW'(T_MIN - 1)) & ~bus.solo[zona])
               | (cnt == CW'(T_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            zona    <= '0;
            got     <= '0;
            asp     <= '0;
            ocupado <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ptr     <= ptr_n;
            zona    <= zona_n;
            got     <= got_n;
            asp     <= asp_n;
            ocupado <= ocupado_n;
        end
    end

    // Next state and registered valve/status values
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        zona_n    = zona;
        got_n     = got;
        asp_n     = asp;
        ocupado_n = ocupado;
        case (state)
            IDLE: begin
                if (caixa_c && found) begin
                    state_n   = IRRIGA;
                    zona_n    = pick;
                    cnt_n     = '0;
                    ocupado_n = 1'b1;
                    if (bus.temperatura[pick] && !bus.umidade[pick]) begin
                        asp_n = oh;
                        got_n = '0;
                    end else begin
                        asp_n = '0;
                        got_n = oh;
                    end
                end
            end
            IRRIGA: begin
                if (cnt != CW'(T_MAX - 1)) begin
                    cnt_n = cnt + CW'(1);
                end
                if (fim) begin
                    state_n   = PAUSA;
                    got_n     = '0;
                    asp_n     = '0;
                    ocupado_n = 1'b0;
                end
            end
            PAUSA: begin
                ptr_n   = (zona == ZW'(N_ZONAS - 1)) ? '0 : zona + ZW'(1);
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.erro        = erro;
    assign bus.alarme      = alarme_c;
    assign bus.ve          = ve;
    assign bus.caixa       = caixa_c;
    assign bus.gotejamento = got;
    assign bus.aspersao    = asp;
    assign bus.zona_ativa  = zona;
    assign bus.ocupado     = ocupado;
endmodule

// File: tb/tb_irrigacao_zonas.sv
// Bench for irrigacao_zonas: directed tank/scheduler scenarios plus random traffic,
// scored cycle by cycle against a behavioural model of the controller.
module tb_irrigacao_zonas;
    localparam int unsigned N     = 4;
    localparam int unsigned DEB   = 3;
    localparam int unsigned T_MIN = 8;
    localparam int unsigned T_MAX = 64;

    typedef struct packed {
        logic       erro;
        logic       alarme;
        logic       ve;
        logic       caixa;
        logic [3:0] got;
        logic [3:0] asp;
        logic [1:0] zona;
        logic       ocup;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irrigacao_zonas_if #(.N_ZONAS(N)) bus ();

    irrigacao_zonas #(
        .N_ZONAS(N), .DEB(DEB), .T_MIN(T_MIN), .T_MAX(T_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;

    // Stimulus variables applied at each tick
    logic [2:0] t_tank = 3'b000;
    logic [3:0] t_solo = 4'b0000;
    logic [3:0] t_umid = 4'b0000;
    logic [3:0] t_temp = 4'b0000;
    logic       t_clr  = 1'b0;
    logic       t_rst  = 1'b0;

    // Reference model state
    logic [2:0] m_filt;
    logic [2:0] m_hist[$];
    logic       m_erro, m_ve;
    bit         m_busy, m_rest, m_asp;
    int         m_zone, m_ptr, m_served;

    // A consistent tank reading is a contiguous fill from the bottom sensor up
    function automatic bit level_ok(logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b011) || (f == 3'b111);
    endfunction

    function automatic void model_reset();
        m_filt = 3'b000;
        m_hist = {};
        for (int i = 0; i < int'(DEB); i++) m_hist.push_back(3'b000);
        m_erro = 1'b0; m_ve = 1'b0;
        m_busy = 0; m_rest = 0; m_asp = 0;
        m_zone = 0; m_ptr = 0; m_served = 0;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        bit ok;
        ok = level_ok(m_filt);
        o.erro   = m_erro;
        o.ve     = m_ve;
        o.caixa  = m_filt[0] && ok && !m_erro;
        o.alarme = !m_filt[0] && ok && !m_erro;
        o.got    = (m_busy && !m_asp) ? (4'(1) << m_zone) : 4'd0;
        o.asp    = (m_busy && m_asp) ? (4'(1) << m_zone) : 4'd0;
        o.zona   = 2'(m_zone);
        o.ocup   = m_busy;
        return o;
    endfunction

    function automatic void model_step();
        bit ok, water, all_same;
        logic e_n, v_n;
        if (!t_rst) begin
            model_reset();
            return;
        end
        ok    = level_ok(m_filt);
        water = m_filt[0] && ok && !m_erro;
        // turn scheduling: m_served = valve-on cycles so far, including this one
        if (m_busy) begin
            if (!water || (m_served >= int'(T_MIN) && !t_solo[m_zone]) || m_served == int'(T_MAX)) begin
                m_busy = 0;
                m_rest = 1;
            end else begin
                m_served++;
            end
        end else if (m_rest) begin
            m_rest = 0;
            m_ptr  = (m_zone + 1) % N;
        end else if (water && t_solo != 4'b0000) begin
            for (int k = 0; k < int'(N); k++) begin
                int z;
                z = (m_ptr + k) % N;
                if (t_solo[z]) begin
                    m_zone = z;
                    break;
                end
            end
            m_busy   = 1;
            m_served = 1;
            m_asp    = t_temp[m_zone] && !t_umid[m_zone];
        end
        e_n = !ok ? 1'b1 : (t_clr ? 1'b0 : m_erro);
        v_n = m_ve;
        if (m_filt[2] || !ok || m_erro) v_n = 1'b0;
        else if (!m_filt[1]) v_n = 1'b1;
        m_erro = e_n;
        m_ve   = v_n;
        // a sensor is accepted once its last DEB samples all show the new value
        m_hist.push_back(t_tank);
        if (m_hist.size() > int'(DEB)) void'(m_hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            if (t_tank[i] != m_filt[i]) begin
                all_same = 1;
                foreach (m_hist[j]) if (m_hist[j][i] != t_tank[i]) all_same = 0;
                if (all_same) m_filt[i] = t_tank[i];
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        rst_n           = t_rst;
        bus.alta        = t_tank[2];
        bus.media       = t_tank[1];
        bus.baixa       = t_tank[0];
        bus.solo        = t_solo;
        bus.umidade     = t_umid;
        bus.temperatura = t_temp;
        bus.clr_erro    = t_clr;
        model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic tick_s();
        tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected observation per clock edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {bus.erro, bus.alarme, bus.ve, bus.caixa, bus.gotejamento,
                         bus.aspersao, bus.zona_ativa, bus.ocupado};
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, mon_a, mon_e);
                end
            end
        end
    end

    logic [2:0] lvl_ok[4]  = '{3'b000, 3'b001, 3'b011, 3'b111};
    logic [2:0] lvl_bad[4] = '{3'b010, 3'b100, 3'b101, 3'b110};

    initial begin
        int turns, len, cnt_g, cnt_a, hold;
        logic prev_oc;

        bus.alta = 0; bus.media = 0; bus.baixa = 0;
        bus.solo = '0; bus.umidade = '0; bus.temperatura = '0; bus.clr_erro = 0;
        model_reset();

        repeat (3) tick();
        t_rst = 1'b1;

        // short glitch is rejected; then fill levels and hysteresis
        t_tank = 3'b011; repeat (2) tick();
        t_tank = 3'b000; repeat (5) tick();
        t_tank = 3'b001; repeat (6) tick();
        t_tank = 3'b111; repeat (6) tick();
        t_tank = 3'b011; repeat (6) tick();

        // inconsistent sensors, clear refused while inconsistent
        t_tank = 3'b101; repeat (4) tick();
        t_clr = 1'b1; tick(); t_clr = 1'b0;
        repeat (3) tick();
        t_tank = 3'b111; repeat (5) tick();
        t_clr = 1'b1; tick(); t_clr = 1'b0;
        repeat (3) tick();

        // all zones requesting, sprinkler mode, full-length turns in rotation
        t_solo = 4'b1111; t_temp = 4'b1111; t_umid = 4'b0000;
        turns = 0; len = 0; prev_oc = 1'b0;
        repeat (4 * 66 + 65) begin
            tick_s();
            if (bus.ocupado && !prev_oc) begin
                chk("rr_zone", int'(bus.zona_ativa), turns % 4);
                chk("rr_aspersao", int'(bus.aspersao), 1 << (turns % 4));
                turns++;
                len = 0;
            end
            if (bus.ocupado) len++;
            if (!bus.ocupado && prev_oc) chk("rr_turn_len", len, int'(T_MAX));
            prev_oc = bus.ocupado;
        end
        chk("rr_turn_count", turns, 5);

        // single zone 2 in drip mode, request drops early: minimum on-time applies
        t_solo = 4'b0100; t_umid = 4'b0100; t_temp = 4'b0000;
        cnt_g = 0; cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) t_solo = 4'b0000;
            tick_s();
            if (bus.gotejamento[2]) cnt_g++;
            if (bus.aspersao != 4'b0000) cnt_a++;
        end
        chk("zone2_drip_cycles", cnt_g, int'(T_MIN));
        chk("zone2_no_sprinkler", cnt_a, 0);
        chk("zone2_zona_ativa", int'(bus.zona_ativa), 2);

        // tank empties mid-turn: immediate abort
        t_solo = 4'b1111; t_temp = 4'b0101;
        repeat (10) tick();
        t_tank = 3'b000;
        repeat (8) tick_s();
        chk("abort_ocupado", int'(bus.ocupado), 0);
        chk("abort_valves", int'({bus.gotejamento, bus.aspersao}), 0);

        // asynchronous reset mid-turn
        t_tank = 3'b111;
        repeat (12) tick();
        t_rst = 1'b0;
        tick();
        #1;
        chk("rst_async_valves", int'({bus.gotejamento, bus.aspersao}), 0);
        chk("rst_async_ocupado", int'(bus.ocupado), 0);
        chk("rst_async_ve", int'(bus.ve), 0);
        chk("rst_async_zona", int'(bus.zona_ativa), 0);
        repeat (2) tick();
        t_rst = 1'b1;

        // random traffic
        hold = 0;
        repeat (3000) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 8) t_tank = lvl_ok[$urandom_range(0, 3)];
                else t_tank = lvl_bad[$urandom_range(0, 3)];
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 11) == 0) t_solo[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) t_umid[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) t_temp[$urandom_range(0, 3)] ^= 1'b1;
            t_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        t_clr = 1'b0;

        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
